// File: rtl/memory_dp.sv
// memory_dp -- dual-port byte-addressed main memory with independent read and
// write channels, per-byte write strobes and a configurable read latency.
// After reset an optional sweep zeroes the array; both channels stay not-ready
// until it completes.
//
// Ports:
//   clk, rst                      clock (rising edge), async active-high reset
//   rd_req_v/rd_req_rdy/rd_addr   read request channel (byte address)
//   rd_rsp_v/rd_rsp_dat/rd_rsp_err read response, RD_LAT cycles after accept
//   wr_req_v/wr_req_rdy/wr_addr/wr_dat/wr_be  write request channel
//   wr_rsp_v/wr_rsp_err           write response, one cycle after accept
//   init_done                     array usable
module memory_dp #(
   parameter int W         = 32,
   parameter int D         = 1024,
   parameter int RD_LAT    = 1,
   parameter int INIT_ZERO = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            rd_req_v,
   output logic            rd_req_rdy,
   input  logic [31:0]     rd_addr,
   output logic            rd_rsp_v,
   output logic [W-1:0]    rd_rsp_dat,
   output logic            rd_rsp_err,
   input  logic            wr_req_v,
   output logic            wr_req_rdy,
   input  logic [31:0]     wr_addr,
   input  logic [W-1:0]    wr_dat,
   input  logic [W/8-1:0]  wr_be,
   output logic            wr_rsp_v,
   output logic            wr_rsp_err,
   output logic            init_done
);

   localparam int NB  = W / 8;
   localparam int OFF = $clog2(NB);
   localparam int AW  = $clog2(D);

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   typedef struct packed {
      logic         err;
      logic [W-1:0] dat;
   } rsp_t;

   // Misaligned when any sub-word bit is set; out of range when any bit above
   // the word index is set. Shift/mask form keeps W=8 and full 32-bit maps legal.
   function automatic logic addr_err(input logic [31:0] a);
      logic [31:0] sub_mask;
      sub_mask = (32'd1 << OFF) - 32'd1;
      return ((a & sub_mask) != 32'd0) || ((a >> (OFF + AW)) != 32'd0);
   endfunction

   state_t          state;
   logic [AW-1:0]   cnt;
   logic [W-1:0]    mem [D];

   logic            rd_acc, wr_acc, rd_err, wr_err;
   logic [AW-1:0]   rd_idx, wr_idx;
   rsp_t            rsp0;
   logic [RD_LAT:1] vld_pipe;
   rsp_t            rsp_pipe [RD_LAT:1];

   assign rd_acc = rd_req_v & rd_req_rdy;
   assign wr_acc = wr_req_v & wr_req_rdy;
   assign rd_err = addr_err(rd_addr);
   assign wr_err = addr_err(wr_addr);
   assign rd_idx = rd_addr[OFF +: AW];
   assign wr_idx = wr_addr[OFF +: AW];

   // Array read happens before the edge, so a same-edge write is not seen
   // (read-first collision behaviour).
   always_comb begin
      rsp0.err = rd_err;
      rsp0.dat = rd_err ? '0 : mem[rd_idx];
   end

   // Storage has no reset; the sweep is the only clearing path.
   always_ff @(posedge clk) begin
      if (state == ST_INIT && INIT_ZERO != 0) begin
         mem[cnt] <= '0;
      end else if (wr_acc && !wr_err) begin
         for (int b = 0; b < NB; b++)
            if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_dat[8*b +: 8];
      end
   end

   // Control FSM; readies and init_done are registered and only change on the
   // INIT->RUN transition.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_INIT;
         cnt        <= '0;
         init_done  <= 1'b0;
         rd_req_rdy <= 1'b0;
         wr_req_rdy <= 1'b0;
         wr_rsp_v   <= 1'b0;
         wr_rsp_err <= 1'b0;
      end else begin
         wr_rsp_v   <= wr_acc;
         wr_rsp_err <= wr_acc & wr_err;
         case (state)
            ST_INIT: begin
               if (INIT_ZERO == 0 || cnt == AW'(D - 1)) begin
                  state      <= ST_RUN;
                  init_done  <= 1'b1;
                  rd_req_rdy <= 1'b1;
                  wr_req_rdy <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= ST_RUN;
         endcase
      end
   end

   // Read response pipeline. Intermediate stages load every cycle; the last
   // stage only loads with a valid response so rd_rsp_dat holds between pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe <= '0;
         for (int i = 1; i <= RD_LAT; i++) rsp_pipe[i] <= '0;
      end else begin
         vld_pipe[1] <= rd_acc;
         if (RD_LAT > 1 || rd_acc) rsp_pipe[1] <= rsp0;
         for (int i = 2; i <= RD_LAT; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            if (i < RD_LAT || vld_pipe[i-1]) rsp_pipe[i] <= rsp_pipe[i-1];
         end
      end
   end

   assign rd_rsp_v   = vld_pipe[RD_LAT];
   assign rd_rsp_dat = rsp_pipe[RD_LAT].dat;
   assign rd_rsp_err = vld_pipe[RD_LAT] & rsp_pipe[RD_LAT].err;

endmodule

// File: tb/tb_memory_dp.sv
// Directed bench for memory_dp (W=32, D=16, RD_LAT=3, INIT_ZERO=1).
// Expected responses go into queues when requests are driven; a negedge
// monitor pops and compares them, including response cycle.
module tb_memory_dp;
   localparam int W = 32, D = 16, RD_LAT = 3;

   logic clk = 1'b0, rst;
   logic rd_req_v, rd_req_rdy, rd_rsp_v, rd_rsp_err;
   logic [31:0] rd_addr, rd_rsp_dat;
   logic wr_req_v, wr_req_rdy, wr_rsp_v, wr_rsp_err, init_done;
   logic [31:0] wr_addr, wr_dat;
   logic [3:0]  wr_be;

   memory_dp #(.W(W), .D(D), .RD_LAT(RD_LAT), .INIT_ZERO(1)) dut (
      .clk(clk), .rst(rst),
      .rd_req_v(rd_req_v), .rd_req_rdy(rd_req_rdy), .rd_addr(rd_addr),
      .rd_rsp_v(rd_rsp_v), .rd_rsp_dat(rd_rsp_dat), .rd_rsp_err(rd_rsp_err),
      .wr_req_v(wr_req_v), .wr_req_rdy(wr_req_rdy), .wr_addr(wr_addr),
      .wr_dat(wr_dat), .wr_be(wr_be),
      .wr_rsp_v(wr_rsp_v), .wr_rsp_err(wr_rsp_err), .init_done(init_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0, n_fail = 0;
   bit mon_en = 1'b0;
   logic [31:0] model [D];

   typedef struct { logic [31:0] dat; logic err; int due; } rexp_t;
   typedef struct { logic err; int due; } wexp_t;
   rexp_t rq[$];
   wexp_t wq[$];
   rexp_t mr;
   wexp_t mw;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic a_err(input logic [31:0] a);
      return (a[1:0] != 2'b0) || (a[31:6] != 26'b0);
   endfunction

   // Drive one cycle of requests at a negedge; accept happens at the next posedge.
   task automatic step(input bit rv, input logic [31:0] ra, input bit wv,
                       input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] wbe);
      rexp_t r;
      wexp_t w;
      @(negedge clk);
      rd_req_v = rv; rd_addr = ra;
      wr_req_v = wv; wr_addr = wa; wr_dat = wd; wr_be = wbe;
      if (rv) begin
         r.err = a_err(ra);
         r.dat = r.err ? 32'h0 : model[ra[5:2]];
         r.due = cyc + RD_LAT;
         rq.push_back(r);
      end
      if (wv) begin
         w.err = a_err(wa);
         w.due = cyc + 1;
         wq.push_back(w);
         if (!w.err)
            for (int b = 0; b < 4; b++)
               if (wbe[b]) model[wa[5:2]][8*b +: 8] = wd[8*b +: 8];
      end
   endtask

   task automatic idle();
      step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
   endtask

   task automatic wait_init(input string tag);
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!init_done && k < 40);
      chk({tag, "_cycles"}, k, D);
      chk({tag, "_rdy"}, {rd_req_rdy, wr_req_rdy}, 2'b11);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (rq.size() == 0) chk("rd_spurious", rd_rsp_v, 1'b0);
         else if (rd_rsp_v) begin
            mr = rq.pop_front();
            chk("rd_cycle", cyc, mr.due);
            chk("rd_dat", rd_rsp_dat, mr.dat);
            chk("rd_err", rd_rsp_err, mr.err);
         end else if (rq[0].due <= cyc) begin
            chk("rd_missing", rd_rsp_v, 1'b1);
            void'(rq.pop_front());
         end
         if (wq.size() == 0) chk("wr_spurious", wr_rsp_v, 1'b0);
         else if (wr_rsp_v) begin
            mw = wq.pop_front();
            chk("wr_cycle", cyc, mw.due);
            chk("wr_err", wr_rsp_err, mw.err);
         end else if (wq[0].due <= cyc) begin
            chk("wr_missing", wr_rsp_v, 1'b1);
            void'(wq.pop_front());
         end
      end
   end

   initial begin
      rst = 1'b1;
      rd_req_v = 0; rd_addr = 0; wr_req_v = 0; wr_addr = 0; wr_dat = 0; wr_be = 0;
      repeat (3) @(negedge clk);
      chk("reset_outs", {rd_req_rdy, wr_req_rdy, rd_rsp_v, rd_rsp_err, wr_rsp_v,
                         wr_rsp_err, init_done, rd_rsp_dat}, 64'h0);
      for (int i = 0; i < D; i++) model[i] = 32'h0;
      mon_en = 1'b1;
      rst = 1'b0;
      wait_init("init");

      // Swept array reads zero
      step(1, 32'h3C, 0, 0, 0, 0);

      // Byte enables
      step(0, 0, 1, 32'h10, 32'hAABBCCDD, 4'hF);
      step(0, 0, 1, 32'h10, 32'h11223344, 4'b0101);
      step(1, 32'h10, 0, 0, 0, 0);

      // Back-to-back reads
      step(0, 0, 1, 32'h0, 32'd1, 4'hF);
      step(0, 0, 1, 32'h4, 32'd2, 4'hF);
      step(0, 0, 1, 32'h8, 32'd3, 4'hF);
      step(1, 32'h0, 0, 0, 0, 0);
      step(1, 32'h4, 0, 0, 0, 0);
      step(1, 32'h8, 0, 0, 0, 0);

      // Error cases; erroneous writes must leave the array untouched
      step(1, 32'h1000, 0, 0, 0, 0);
      step(1, 32'h2, 0, 0, 0, 0);
      step(0, 0, 1, 32'h1000, 32'hFFFFFFFF, 4'hF);
      step(0, 0, 1, 32'h6, 32'hFFFFFFFF, 4'hF);
      step(0, 0, 1, 32'h14, 32'hDEADBEEF, 4'h0);
      for (int i = 0; i < D; i++) step(1, 32'(i * 4), 0, 0, 0, 0);

      // Same-edge collision returns old data; the next read sees new data
      step(0, 0, 1, 32'h8, 32'd5, 4'hF);
      step(1, 32'h8, 1, 32'h8, 32'd9, 4'hF);
      step(1, 32'h8, 0, 0, 0, 0);

      // Mixed random traffic, occasionally with bad addresses
      for (int i = 0; i < 60; i++) begin
         logic [31:0] ra, wa;
         ra = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, D - 1) * 4);
         wa = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, D - 1) * 4);
         step(1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)), wa, $urandom,
              4'($urandom_range(0, 15)));
      end
      repeat (RD_LAT + 2) idle();
      chk("drain", rq.size() + wq.size(), 0);

      // Reset with two reads in flight: their responses must never appear
      step(1, 32'h0, 0, 0, 0, 0);
      step(1, 32'h4, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b1;
      rd_req_v = 0; wr_req_v = 0;
      rq.delete();
      wq.delete();
      #1;
      chk("midreset_outs", {rd_req_rdy, wr_req_rdy, rd_rsp_v, rd_rsp_err, wr_rsp_v,
                            wr_rsp_err, init_done, rd_rsp_dat}, 64'h0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < D; i++) model[i] = 32'h0;
      wait_init("reinit");
      step(1, 32'h10, 0, 0, 0, 0);
      step(1, 32'h8, 0, 0, 0, 0);
      repeat (RD_LAT + 2) idle();
      chk("drain_end", rq.size() + wq.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
